// File: rtl/uart_tx_packet_if.sv
// Controller-side bundle for the two-byte UART packet transmitter.
// The master drives the request and packet word; the slave returns the line and status.
interface uart_tx_packet_if;
    logic        send_data;
    logic [15:0] buffer;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output send_data,
        output buffer,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  send_data,
        input  buffer,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_packet.sv
// Sends a 16-bit packet as two back-to-back 8N1 UART frames, high byte first,
// on the rising edge of send_data; done pulses once after the second stop bit.
module uart_tx_packet #(
    parameter int CLKS_PER_BIT = 5208
) (
    input logic             clock,
    input logic             reset,
    uart_tx_packet_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic        byte_idx;
    logic [15:0] hold;
    logic [7:0]  shift;
    logic        send_prev;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;

    logic        request;
    logic        bit_end;
    logic [7:0]  cur_byte;

    assign request  = bus.send_data & ~send_prev;
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign cur_byte = byte_idx ? hold[7:0] : hold[15:8];

    assign bus.tx   = tx_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // send_prev resets high so a request already asserted at release is ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= 1'b0;
            hold      <= '0;
            shift     <= '0;
            send_prev <= 1'b1;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            send_prev <= bus.send_data;
            done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (request) begin
                        hold     <= bus.buffer;
                        byte_idx <= 1'b0;
                        state    <= START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_r    <= cur_byte[0];
                        shift   <= {1'b0, cur_byte[7:1]};
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    // shift holds the bits still to go, next one in bit 0
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_r    <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= START;
                            tx_r     <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_packet.sv
// Scoreboarded bench: stimulus queues expected packets, a line monitor decodes
// tx at mid-bit and compares each packet when done fires.
module tb_uart_tx_packet;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic def_reset = 1'b1;

    always #5 clock = ~clock;

    uart_tx_packet_if dut_if ();
    uart_tx_packet_if def_if ();

    uart_tx_packet #(.CLKS_PER_BIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if)
    );

    uart_tx_packet dut_def (
        .clock (clock),
        .reset (def_reset),
        .bus   (def_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          exp_done = 0;
    int          done_count = 0;

    int          mon_off = -1;
    logic [15:0] mon_word = '0;
    logic [15:0] mon_exp;
    int          bit_n;
    int          pos;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int width, input bit push);
        @(posedge clock);
        #1;
        dut_if.buffer    = word;
        dut_if.send_data = 1'b1;
        if (push) begin
            exp_q.push_back(word);
            exp_done++;
        end
        repeat (width) @(posedge clock);
        #1;
        dut_if.send_data = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clock);
            if (dut_if.done) break;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no done within %0d cycles expected done", name, budget);
        end
    endtask

    always @(negedge clock) begin
        if (dut_if.done) done_count++;
    end

    // Line monitor: offset 0 is the first sample after tx falls; bit b spans offsets 4b..4b+3
    always @(negedge clock) begin
        if (reset) begin
            mon_off = -1;
        end else begin
            if (mon_off < 0 && dut_if.tx == 1'b0) begin
                mon_off  = 0;
                mon_word = '0;
                checkOutput("busy_at_start", int'(dut_if.busy), 1);
            end
            if (mon_off >= 0) begin
                if (mon_off % 4 == 2) begin
                    bit_n = mon_off / 4;
                    pos   = bit_n % 10;
                    if (pos == 0)
                        checkOutput("start_bit", int'(dut_if.tx), 0);
                    else if (pos == 9)
                        checkOutput("stop_bit", int'(dut_if.tx), 1);
                    else if (bit_n < 10)
                        mon_word[8 + pos - 1] = dut_if.tx;
                    else
                        mon_word[pos - 1] = dut_if.tx;
                end
                if (mon_off == 79)
                    checkOutput("done_early", int'(dut_if.done), 0);
                if (mon_off == 80) begin
                    checkOutput("done_at_80", int'(dut_if.done), 1);
                    checkOutput("busy_after_packet", int'(dut_if.busy), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_packet: got 0x%0h expected none", mon_word);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("packet_word", int'(mon_word), int'(mon_exp));
                    end
                    mon_off = -1;
                end else begin
                    mon_off++;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit low_seen;
        int low;
        dut_if.send_data = 1'b0;
        dut_if.buffer    = '0;
        def_if.send_data = 1'b0;
        def_if.buffer    = '0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_tx", int'(dut_if.tx), 1);
        checkOutput("reset_busy", int'(dut_if.busy), 0);
        checkOutput("reset_done", int'(dut_if.done), 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);

        // Basic packet, two-cycle request
        applyStimulus(16'h0208, 2, 1'b1);
        waitDone("basic_done", 200);
        @(negedge clock);
        checkOutput("basic_idle_tx", int'(dut_if.tx), 1);
        checkOutput("basic_idle_busy", int'(dut_if.busy), 0);
        repeat (5) @(posedge clock);

        // Request while busy is dropped; buffer change must not leak in
        applyStimulus(16'h1F00, 1, 1'b1);
        repeat (28) @(posedge clock);
        #1;
        dut_if.buffer    = 16'hFFFF;
        dut_if.send_data = 1'b1;
        @(posedge clock);
        #1;
        dut_if.send_data = 1'b0;
        waitDone("busy_req_done", 200);
        repeat (100) @(posedge clock);
        checkOutput("busy_req_no_second", int'(dut_if.busy), 0);

        // Back-to-back: new request in the done cycle
        applyStimulus(16'h5A3C, 1, 1'b1);
        waitDone("b2b_first_done", 200);
        checkOutput("done_cycle_tx", int'(dut_if.tx), 1);
        dut_if.buffer    = 16'hAA55;
        dut_if.send_data = 1'b1;
        exp_q.push_back(16'hAA55);
        exp_done++;
        @(negedge clock);
        checkOutput("b2b_start_next_cycle", int'(dut_if.tx), 0);
        checkOutput("b2b_busy", int'(dut_if.busy), 1);
        dut_if.send_data = 1'b0;
        waitDone("b2b_second_done", 200);
        repeat (5) @(posedge clock);

        // Reset during data bit 3 of the low byte, request held through release
        @(posedge clock);
        #1;
        dut_if.buffer    = 16'h3C5A;
        dut_if.send_data = 1'b1;
        repeat (58) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_tx", int'(dut_if.tx), 1);
        checkOutput("abort_busy", int'(dut_if.busy), 0);
        checkOutput("abort_done", int'(dut_if.done), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (dut_if.tx == 1'b0 || dut_if.busy) low_seen = 1'b1;
        end
        checkOutput("held_request_ignored", int'(low_seen), 0);
        dut_if.send_data = 1'b0;
        applyStimulus(16'hC3A5, 1, 1'b1);
        waitDone("after_reset_done", 200);
        repeat (5) @(posedge clock);

        // Default baud: start plus eight zero data bits hold tx low for 9 bit-times
        @(posedge clock);
        #1;
        def_reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        def_if.send_data = 1'b1;
        low = 0;
        while (def_if.tx != 1'b0 && low < 10) begin
            @(negedge clock);
            low++;
        end
        checkOutput("default_fall", int'(def_if.tx), 0);
        low = 0;
        while (def_if.tx == 1'b0 && low < 60000) begin
            low++;
            @(negedge clock);
        end
        checkOutput("default_low_run", low, 9 * 5208);
        checkOutput("default_busy", int'(def_if.busy), 1);
        def_reset = 1'b1;

        repeat (5) @(posedge clock);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("done_count", done_count, exp_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_packet.md
UART_TX_PACKET -- requirements
Module: uart_tx_packet

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 clock  input  1  native 50 MHz board clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 send_data  input  1  packet-send request from the main controller; level signal whose rising edge requests one packet.
REQ-005 buffer  input  16  packet to transmit: [15:8] response code, [7:0] payload byte.
REQ-006 tx  output  1  UART serial line, 8N1, idle high.
REQ-007 busy  output  1  high while a packet is in flight.
REQ-008 done  output  1  one-cycle pulse when the second stop bit completes.

Function
REQ-009 The block SHALL use one clock; reset SHALL be asynchronous and active-high; no other clock or reset domain SHALL exist.
REQ-010 States SHALL be IDLE, START, DATA and STOP, plus a 1-bit byte index (0 = high byte, 1 = low byte).
REQ-011 Request detect: register send_prev <= send_data every cycle; request = send_data & ~send_prev.
REQ-012 In IDLE, on a request at edge k: latch buffer into a 16-bit holding register, index = 0, state -> START, tx = 0 and busy = 1 from edge k onward (1-cycle latency).
REQ-013 A request outside IDLE SHALL be discarded, neither queued nor counted; buffer changes after the latch SHALL NOT affect the packet in flight.
REQ-014 Bit counter: every bit (start, 8 data, stop) SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-015 START drives tx = 0, then goes to DATA.
REQ-016 DATA sends the selected byte LSB first (bit 0 through bit 7), then goes to STOP.
REQ-017 STOP drives tx = 1.
REQ-018 At the end of STOP with index 0: index = 1, state -> START (no idle gap between frames).
REQ-019 At the end of STOP with index 1: state -> IDLE, busy = 0, and done = 1 for exactly that one cycle.
REQ-020 Total packet time SHALL be 20*CLKS_PER_BIT cycles from tx falling to done asserting.
REQ-021 A request in the cycle done is high (first IDLE cycle) SHALL be accepted per REQ-012, giving back-to-back packets with no idle bit.
REQ-022 tx SHALL be registered and glitch-free; in IDLE tx = 1.
REQ-023 A send_data pulse of any width >= 1 cycle SHALL produce exactly one packet; send_data must be low for at least one cycle between requests.

Reset
REQ-024 Asserting reset SHALL immediately force: state IDLE, tx = 1, busy = 0, done = 0, counters = 0, index = 0, holding register = 0.
REQ-025 Reset SHALL force send_prev = 1, so send_data already high at reset release does not start a packet.
REQ-026 Reset mid-packet SHALL abort the frame; tx returns high with no done pulse; the next packet after release begins with a full start bit.

Verification (CLKS_PER_BIT = 4 unless noted)
REQ-027 Basic packet:
- Stimulus: buffer = 16'h0208, send_data high for 2 cycles.
- Required response: tx = start, 0x02 LSB-first, stop, start, 0x08 LSB-first, stop; each bit 4 cycles; done at cycle 80 after tx falls; busy low again.
REQ-028 Request while busy:
- Stimulus: second send_data edge with buffer = 16'hFFFF at cycle 30 of packet 16'h1F00.
- Required response: only 0x1F, 0x00 sent; exactly one done pulse.
REQ-029 Back-to-back:
- Stimulus: new edge in the done cycle with buffer = 16'hAA55.
- Required response: next start bit begins the following cycle; tx never idles between packets.
REQ-030 Reset mid-frame:
- Stimulus: assert reset during bit 3 of the low byte.
- Required response: tx = 1 and busy = 0 immediately, no done pulse; send_data held high through release sends nothing until it toggles low then high.
REQ-031 Default baud:
- Stimulus: CLKS_PER_BIT = 5208, buffer = 16'h0000.
- Required response: each bit is 5208 cycles, packet is 104160 cycles, tx low for 9 bit-times per frame.
